// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and instruction_mem.
package imem_pkg;

    localparam int IMEM_DEPTH_WORDS = 64;
    localparam int WORD_BYTES       = 4;
    localparam int XLEN             = 32;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian stream bytes into a 32-bit word; word_full flags the accept of the last lane.
module word_assembler
    import imem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            accept,
    input  logic [7:0]      byte_data,
    output logic [1:0]      byte_idx,
    output logic            word_full,
    output logic [XLEN-1:0] word_next
);

    logic [XLEN-1:0] word_q;

    // word_next already carries the byte being accepted, so the loader can capture the whole word on the 4th accept
    always_comb begin
        word_next = word_q;
        word_next[{byte_idx, 3'b000} +: 8] = byte_data;
    end

    assign word_full = accept && (byte_idx == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            word_q   <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a byte stream, then releases the core from reset.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             error
);

    loader_state_t    state;
    loader_state_t    next_state;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] num_lat;
    logic             num_ok;
    logic             start_ok;
    logic             start_load;
    logic             last_word;
    logic             accept;
    logic             asm_clear;
    logic [1:0]       byte_idx;
    logic             word_full;
    logic [XLEN-1:0]  word_next;

    assign num_ok     = (num_words != '0) && (num_words <= CNT_W'(DEPTH_WORDS));
    assign start_ok   = (state == IDLE) || (state == DONE) || (state == ERR);
    assign start_load = start && !abort && start_ok && num_ok;
    assign last_word  = (word_idx == num_lat - CNT_W'(1));
    assign accept     = byte_valid && byte_ready;
    assign asm_clear  = abort || start_load || (state == WRITE);

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (asm_clear),
        .accept    (accept),
        .byte_data (byte_data),
        .byte_idx  (byte_idx),
        .word_full (word_full),
        .word_next (word_next)
    );

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) next_state = num_ok ? RECV : ERR;
                done  = (state == DONE);
                error = (state == ERR);
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_full) next_state = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                busy       = 1'b1;
                next_state = last_word ? DONE : RECV;
            end
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // core_rst_n is registered off next_state so it changes exactly on the edge entering/leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            core_rst_n <= 1'b0;
        end else begin
            state      <= next_state;
            core_rst_n <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            num_lat  <= '0;
        end else if (start_load) begin
            word_idx <= '0;
            num_lat  <= num_words;
        end else if (state == WRITE && !abort) begin
            word_idx <= word_idx + CNT_W'(1);
        end
    end

    // Address and data are captured with the 4th byte and then held until the next word completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (word_full && !abort) begin
            mem_addr  <= 32'({word_idx, 2'b00});
            mem_wdata <= word_next;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-list reference model.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int DEPTH = IMEM_DEPTH_WORDS;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, mem_we, core_rst_n, busy, done, error;
    logic [31:0]   mem_addr, mem_wdata;

    int          testCount = 0;
    int          failCount = 0;
    logic [7:0]  txQ[$];
    wr_t         expQ[$];
    logic [31:0] shadowMem [DEPTH];
    logic [31:0] lastAddr = '0;
    logic        prevWe = 1'b0;

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference word i of the current transfer: four stream bytes, little-endian
    function automatic logic [31:0] refWord(input int i);
        return {txQ[4*i+3], txQ[4*i+2], txQ[4*i+1], txQ[4*i]};
    endfunction

    task automatic pushExpected(input int nWords);
        for (int i = 0; i < nWords; i++) expQ.push_back('{addr: 32'(i * 4), data: refWord(i)});
    endtask

    task automatic fillRandom(input int nBytes);
        txQ.delete();
        for (int i = 0; i < nBytes; i++) txQ.push_back(8'($urandom));
    endtask

    // One-cycle start/abort pulse driven between falling edges
    task automatic applyStimulus(input logic doStart, input logic doAbort, input int num);
        start     = doStart;
        abort     = doAbort;
        num_words = CW'(num);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // gap < 0: random valid; gap >= 0: valid after exactly gap idle cycles
    task automatic sendBytes(input int first, input int last, input int gap);
        int idx = first;
        int idle = 0;
        int budget = 0;
        logic accepted;
        while (idx < last && budget < 100 * (last - first) + 50) begin
            if (gap < 0) byte_valid = ($urandom_range(99) < 60);
            else byte_valid = (idle >= gap);
            byte_data = byte_valid ? txQ[idx] : 8'($urandom);
            accepted  = byte_valid && byte_ready;
            @(negedge clk);
            budget++;
            if (accepted) begin
                idx++;
                idle = 0;
                if (idx % 4 == 0) checkOutput("write_latency", {31'b0, mem_we}, 32'd1);
            end else if (!byte_valid) begin
                idle++;
            end
        end
        byte_valid = 1'b0;
        checkOutput("bytes_sent", 32'(idx), 32'(last));
    endtask

    task automatic waitDone(input string tag);
        int c = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_error"}, {31'b0, error}, 32'd0);
        checkOutput({tag, "_core_rst"}, {31'b0, core_rst_n}, 32'd0);
    endtask

    task automatic fullLoad(input int n, input int gap);
        fillRandom(4 * n);
        pushExpected(n);
        applyStimulus(1'b1, 1'b0, n);
        checkOutput("load_busy", {31'b0, busy}, 32'd1);
        checkOutput("load_core_rst", {31'b0, core_rst_n}, 32'd0);
        sendBytes(0, 4 * n, gap);
        waitDone("load_done");
        checkOutput("done_core_rst", {31'b0, core_rst_n}, 32'd1);
        checkOutput("done_pending", 32'(expQ.size()), 32'd0);
        for (int i = 0; i < n; i++) checkOutput("readback", shadowMem[i], refWord(i));
    endtask

    // Write scoreboard: every strobe must match the next expected word, last exactly one cycle, with byte_ready low
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checkOutput("ready_in_write", {31'b0, byte_ready}, 32'd0);
            checkOutput("write_one_cycle", {31'b0, prevWe}, 32'd0);
            checkOutput("write_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                checkOutput("write_addr", mem_addr, expQ[0].addr);
                checkOutput("write_data", mem_wdata, expQ[0].data);
                void'(expQ.pop_front());
            end
            shadowMem[mem_addr[7:2]] = mem_wdata;
            lastAddr = mem_addr;
        end
        prevWe = rst_n && mem_we;
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkIdle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load with the known two-instruction program
        txQ = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h00, 8'hA0, 8'h00};
        pushExpected(2);
        applyStimulus(1'b1, 1'b0, 2);
        sendBytes(0, 8, 0);
        waitDone("basic_done");
        checkOutput("basic_core_rst", {31'b0, core_rst_n}, 32'd1);
        checkOutput("basic_rd0", shadowMem[0], 32'h0050_0013);
        checkOutput("basic_rd1", shadowMem[1], 32'h00A0_00B3);

        // Async reset in the middle of a word
        fillRandom(8);
        applyStimulus(1'b1, 1'b0, 2);
        sendBytes(0, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("arst_addr", mem_addr, 32'd0);
        checkOutput("arst_wdata", mem_wdata, 32'd0);
        checkIdle("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fullLoad(2, -1);

        // Backpressure with fixed 3-cycle gaps, then random gaps and various sizes
        fullLoad(3, 3);
        for (int k = 0; k < 5; k++) fullLoad($urandom_range(6, 1), (k % 2 == 0) ? -1 : 0);

        // Reload from DONE drops core reset on the next edge
        checkOutput("pre_reload_core_rst", {31'b0, core_rst_n}, 32'd1);
        fullLoad(1, 0);

        // start + abort together from DONE: abort wins
        applyStimulus(1'b1, 1'b1, 1);
        checkIdle("startabort");

        // start during RECV is ignored
        fillRandom(4);
        pushExpected(1);
        applyStimulus(1'b1, 1'b0, 1);
        sendBytes(0, 2, 0);
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("ign_busy", {31'b0, busy}, 32'd1);
        checkOutput("ign_error", {31'b0, error}, 32'd0);
        sendBytes(2, 4, -1);
        waitDone("ign_done");

        // Abort part-way through word 1
        fillRandom(8);
        pushExpected(1);
        applyStimulus(1'b1, 1'b0, 2);
        sendBytes(0, 6, 0);
        applyStimulus(1'b0, 1'b1, 0);
        checkIdle("abort");
        repeat (8) @(negedge clk);
        checkOutput("abort_pending", 32'(expQ.size()), 32'd0);
        fullLoad(1, -1);
        checkOutput("abort_reload_addr", lastAddr, 32'd0);

        // Bounds on num_words
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("zero_error", {31'b0, error}, 32'd1);
        checkOutput("zero_core_rst", {31'b0, core_rst_n}, 32'd0);
        applyStimulus(1'b1, 1'b0, 65);
        checkOutput("err_stays", {31'b0, error}, 32'd1);
        applyStimulus(1'b0, 1'b1, 0);
        checkIdle("err_abort");
        applyStimulus(1'b1, 1'b0, 65);
        checkOutput("over_error", {31'b0, error}, 32'd1);
        repeat (4) @(negedge clk);
        fullLoad(DEPTH, -1);
        checkOutput("full_last_addr", lastAddr, 32'h0000_00FC);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time controller that fills the single-cycle core's instruction memory from a byte stream (UART/debug bridge), then releases the core from reset.
- Sits between the host byte source and the write port of instruction_mem. Fetch-side read timing is unchanged.
- Holds the core in reset while loading, so fetch and load never contend for the memory.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words.
- CNT_W, $clog2(DEPTH_WORDS)+1, width of word counters and of num_words.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin a load of num_words words.
- abort  in  1  one-cycle pulse: cancel the load and return to IDLE.
- num_words  in  CNT_W  word count, sampled on start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte, little-endian within each word.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  32  byte address, always word aligned (bits[1:0]=0).
- mem_wdata  out  32  assembled instruction word.
- core_rst_n  out  1  active-low reset to the core, low while loading.
- busy  out  1  high in RECV or WRITE.
- done  out  1  high in DONE.
- error  out  1  high in ERR.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including core_rst_n=0 (core held in reset). Word index and byte index are both 0.
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE, start=1:
  - num_words in 1..DEPTH_WORDS: latch it, clear indices, go to RECV.
  - num_words=0 or >DEPTH_WORDS: go to ERR.
- RECV:
  - byte_ready=1.
  - On byte_valid&&byte_ready, byte_data goes to lane byte_idx (bits 8*byte_idx+:8) and byte_idx increments.
  - Accepting the 4th byte (byte_idx==3) moves the state to WRITE on the next edge.
  - byte_valid=0 holds the state indefinitely. No timeout.
- WRITE, exactly 1 cycle:
  - mem_we=1, mem_addr=word_idx<<2, mem_wdata=assembled word; byte_ready=0.
  - Next edge: word_idx++ and byte_idx=0.
  - If word_idx==num_words-1, go to DONE; otherwise go to RECV.
- Throughput: max 1 word per 5 cycles (4 accepts + 1 write). The write cycle follows the 4th accept by exactly 1 clock.
- DONE:
  - done=1, core_rst_n=1 (registered, so it rises on the edge entering DONE).
  - mem_we=0, byte_ready=0.
  - A new start re-enters the IDLE start check that same cycle: core_rst_n drops to 0 on the next edge, then RECV or ERR.
- ERR:
  - error=1, core_rst_n=0.
  - Leave only via abort (to IDLE) or a valid start (to RECV).
- abort, in any state: go to IDLE next edge.
  - Partial word is discarded; memory words already written stay written; core_rst_n=0.
- abort and start in the same cycle: abort wins.
- start in RECV or WRITE: ignored.
- Bytes presented while byte_ready=0 are not consumed.
- Async reset mid-load: immediate return to IDLE, all outputs 0. No write is completed.
- mem_we is never high outside WRITE. mem_addr/mem_wdata hold their last value when mem_we=0.

Decomposition:
- Package imem_pkg:
  - enum loader_state_t {IDLE, RECV, WRITE, DONE, ERR}
  - IMEM_DEPTH_WORDS=64, WORD_BYTES=4, XLEN=32. Shared with instruction_mem.
- One sub-module, word_assembler: byte_idx counter, lane shift-in, word_full flag, clear input. The FSM stays in imem_loader.

Test Plan:
- Reset: rst_n=0 mid-RECV -> all outputs 0, core_rst_n=0 asynchronously, state IDLE. Release, then start num_words=2 -> normal load.
- Basic load: start num_words=2, bytes 13,00,50,00 then B3,00,A0,00 -> two single-cycle writes:
  - mem_addr=0x00, wdata=0x00500013
  - mem_addr=0x04, wdata=0x00A000B3
  - then done=1, core_rst_n=1.
  - Readback via instruction_mem at 0x0 and 0x4 matches.
- Backpressure: byte_valid gapped 3 cycles between bytes, and byte_valid=1 during WRITE -> no byte lost or duplicated; WRITE lasts exactly 1 cycle; byte_ready=0 in WRITE.
- Bounds:
  - num_words=0 -> error=1, no mem_we.
  - num_words=65 -> error=1, no mem_we.
  - num_words=64 -> last write at mem_addr=0xFC, then DONE.
- Abort: abort after 2 bytes of word 1 -> IDLE, no write to 0x04, core_rst_n=0. A subsequent start reloads from address 0x00.
- Reload from DONE: start num_words=1 -> core_rst_n falls 1 cycle later, write at 0x00, DONE again. start+abort in the same cycle -> IDLE.
